// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Used by both the top (mux_rr_arbiter) and the priority picker (rr_pick4).
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) s = SEL_W'(i);
        end
        return s;
    endfunction

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request scanning from last+1, wrapping 3->0.
// Shared by the idle pick and the on-release re-arbitration.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt
);

    logic [SEL_W-1:0] idx;

    // i == NUM_REQ wraps back to last itself, so it is scanned last
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        gnt = found ? sel_to_onehot(sel) : '0;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer owning the select of the shared 4:1 mux.
// Optional per-requester transfer counters when ARB_GRANT_STATS_EN is defined.
//
// state | meaning
// IDLE  | no grant; out_valid=0, picks a winner from last+1 when req!=0
// GRANT | sel/gnt frozen, out_valid=1; burst counted per accepted transfer
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned DATA_W    = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
`ifdef ARB_GRANT_STATS_EN
    output logic               xfer,
    output logic [NUM_REQ*16-1:0] grant_cnt,
    input  logic               stats_clr
`else
    output logic               xfer
`endif
);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_GRANT = GRANT;
    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    if (MAX_BURST < 1 || MAX_BURST > 15 || DATA_W < 1) begin : g_bad_param
        $error("mux_rr_arbiter: MAX_BURST must be 1..15 and DATA_W >= 1");
    end

    logic [0:0]         state;
    logic [SEL_W-1:0]   last;
    logic [3:0]         cnt;
    logic [NUM_REQ-1:0] pick_req;
    logic [SEL_W-1:0]   pick_last;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_sel;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               release_grant;

    // A reset edge must not see a completed transfer.
    assign xfer = out_valid & out_ready & ~rst;

    // While granted, the current owner is masked so others win the rotation.
    assign pick_req  = (state == S_GRANT) ? (req & ~gnt) : req;
    assign pick_last = (state == S_GRANT) ? sel : last;

    assign release_grant = (state == S_GRANT) &&
                           (!req[sel] || (xfer && (cnt == LAST_CNT)));

    rr_pick4 u_pick (
        .req   (pick_req),
        .last  (pick_last),
        .found (pick_found),
        .sel   (pick_sel),
        .gnt   (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sel       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            last      <= SEL_W'(NUM_REQ - 1);
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state     <= S_GRANT;
                        sel       <= pick_sel;
                        gnt       <= pick_gnt;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_grant) begin
                        last <= sel;
                        cnt  <= '0;
                        if (pick_found) begin
                            sel <= pick_sel;
                            gnt <= pick_gnt;
                        end else begin
                            state     <= S_IDLE;
                            sel       <= '0;
                            gnt       <= '0;
                            out_valid <= 1'b0;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    sel       <= '0;
                    gnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_GRANT_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    // Clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (xfer) begin
            stat_q[sel] <= stat_q[sel] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table on a MAX_BURST=4 instance,
// fairness sequence on a MAX_BURST=1 instance, scoreboard queue of expected outputs.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst, rst1;
    logic [3:0]  req, req1;
    logic        out_ready, rdy1;
    logic [1:0]  sel, sel1;
    logic [3:0]  gnt, gnt1;
    logic        out_valid, valid1;
    logic        xfer, xfer1;
    logic [63:0] gc4, gc1;
    logic        stats_clr, stats_clr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_BURST(4), .DATA_W(13)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
`ifdef ARB_GRANT_STATS_EN
        .xfer      (xfer),
        .grant_cnt (gc4),
        .stats_clr (stats_clr)
`else
        .xfer      (xfer)
`endif
    );

    mux_rr_arbiter #(.MAX_BURST(1), .DATA_W(13)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .req       (req1),
        .out_ready (rdy1),
        .sel       (sel1),
        .gnt       (gnt1),
        .out_valid (valid1),
`ifdef ARB_GRANT_STATS_EN
        .xfer      (xfer1),
        .grant_cnt (gc1),
        .stats_clr (stats_clr1)
`else
        .xfer      (xfer1)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       v;
        logic       x;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       v;
        logic       x;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[27];

    task automatic compare(input int d);
        exp_t e;
        logic [1:0] a_sel;
        logic [3:0] a_gnt;
        logic a_v, a_x;
        e = sb.pop_front();
        if (d == 0) begin a_sel = sel;  a_gnt = gnt;  a_v = out_valid; a_x = xfer;  end
        else        begin a_sel = sel1; a_gnt = gnt1; a_v = valid1;    a_x = xfer1; end
        checks++;
        if (a_sel !== e.sel || a_gnt !== e.gnt || a_v !== e.v || a_x !== e.x) begin
            failures++;
            $display("FAIL %s: got sel=%b gnt=%b valid=%b xfer=%b, want sel=%b gnt=%b valid=%b xfer=%b",
                     e.name, a_sel, a_gnt, a_v, a_x, e.sel, e.gnt, e.v, e.x);
        end
    endtask

    task automatic step(input int d, input logic r, input logic [3:0] rq, input logic rd,
                        input logic [1:0] es, input logic [3:0] eg, input logic ev,
                        input logic ex, input string nm);
        exp_t e;
        @(negedge clk);
        if (d == 0) begin rst = r;  req = rq;  out_ready = rd; end
        else        begin rst1 = r; req1 = rq; rdy1 = rd;      end
        e.sel = es; e.gnt = eg; e.v = ev; e.x = ex; e.name = nm;
        sb.push_back(e);
        #1;
        compare(d);
    endtask

    task automatic check_cnt(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0; stats_clr = 1'b0;
        rst1 = 1'b1; req1 = '0; rdy1 = 1'b0; stats_clr1 = 1'b0;

        //          rst  req     rdy   sel    gnt     v     x
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}; // reset held 2nd cycle
        tbl[1]  = '{1'b0, 4'b0100, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0}; // idle, req rises
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 2'b10, 4'b0100, 1'b1, 1'b1}; // burst 1
        tbl[3]  = '{1'b0, 4'b0100, 1'b1, 2'b10, 4'b0100, 1'b1, 1'b1}; // burst 2
        tbl[4]  = '{1'b0, 4'b0100, 1'b1, 2'b10, 4'b0100, 1'b1, 1'b1}; // burst 3
        tbl[5]  = '{1'b0, 4'b0100, 1'b1, 2'b10, 4'b0100, 1'b1, 1'b1}; // burst 4, release
        tbl[6]  = '{1'b0, 4'b0100, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0}; // one idle bubble
        tbl[7]  = '{1'b0, 4'b0100, 1'b1, 2'b10, 4'b0100, 1'b1, 1'b1}; // re-grant req 2
        tbl[8]  = '{1'b0, 4'b0010, 1'b0, 2'b10, 4'b0100, 1'b1, 1'b0}; // req2 drops, no xfer
        tbl[9]  = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0}; // backpressure 1
        tbl[10] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0}; // backpressure 5
        tbl[14] = '{1'b0, 4'b0010, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b1}; // ready rises: xfer
        tbl[15] = '{1'b0, 4'b1000, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0}; // req1 drops -> req3
        tbl[16] = '{1'b0, 4'b1001, 1'b1, 2'b11, 4'b1000, 1'b1, 1'b1}; // req3 xfer 1
        tbl[17] = '{1'b0, 4'b1001, 1'b1, 2'b11, 4'b1000, 1'b1, 1'b1}; // req3 xfer 2
        tbl[18] = '{1'b0, 4'b0001, 1'b0, 2'b11, 4'b1000, 1'b1, 1'b0}; // req3 drops
        tbl[19] = '{1'b0, 4'b0001, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b1}; // wrap to 0, no bubble
        tbl[20] = '{1'b1, 4'b0001, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b0}; // rst mid-burst
        tbl[21] = '{1'b0, 4'b0010, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0}; // aborted grant
        tbl[22] = '{1'b0, 4'b0010, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b1}; // first grant req 1
        tbl[23] = '{1'b0, 4'b0011, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b1}; // req0 waits
        tbl[24] = '{1'b0, 4'b0011, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b1};
        tbl[25] = '{1'b0, 4'b0011, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b1}; // 4th xfer, release
        tbl[26] = '{1'b0, 4'b0011, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b1}; // req0 without bubble

        for (int i = 0; i < 27; i++) begin
            step(0, tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].sel, tbl[i].gnt,
                 tbl[i].v, tbl[i].x, $sformatf("vec%0d", i));
        end

        // Fairness with MAX_BURST=1: one transfer per grant, strict rotation.
        step(1, 1'b1, 4'b1111, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, "rr_reset");
        step(1, 1'b0, 4'b1111, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, "rr_idle");
        for (int i = 0; i < 8; i++) begin
            logic [1:0] s;
            logic [3:0] oh;
            s  = 2'(i % 4);
            oh = 4'b0001 << s;
            step(1, 1'b0, 4'b1111, 1'b1, s, oh, 1'b1, 1'b1, $sformatf("rr%0d", i));
        end

`ifdef ARB_GRANT_STATS_EN
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            check_cnt($sformatf("stats%0d", i), gc1[i*16 +: 16], 16'd2);
        stats_clr1 = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            check_cnt($sformatf("stats_clr%0d", i), gc1[i*16 +: 16], 16'd0);
        stats_clr1 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
